// File: rtl/sgf_divider_seq.sv
// Sequential radix-2 restoring divider for FPU significands.
// Computes floor(A * 2^SW / B), one quotient bit per clock, MSB first,
// plus a sticky flag that is set when the final partial remainder is nonzero.
module sgf_divider_seq #(
    parameter int unsigned SW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] Data_A_i,
    input  logic [SW-1:0] Data_B_i,
    output logic          busy_o,
    output logic          ready_o,
    output logic [SW:0]   sgf_quot_o,
    output logic          sticky_o,
    output logic          div_zero_o
);

    // The counter holds the iteration index 0..SW, so it needs to count SW+1 values.
    localparam int unsigned CW = $clog2(SW + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [SW:0]   rem_q, rem_d;
    logic [SW-1:0] divisor_q, divisor_d;
    logic [SW:0]   qsr_q, qsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic [SW:0]   quot_q, quot_d;
    logic          sticky_q, sticky_d;
    logic          dz_q, dz_d;

    // Single restoring step. The compare and subtract are SW+1 bits wide.
    // The remainder stays below 2B, so the left shift loses nothing for
    // normalized operands.
    logic [SW:0] divisor_ext;
    logic [SW:0] rem_sub;
    logic        q_bit;
    logic [SW:0] rem_next;

    // Datapath for one iteration of the restoring step
    always_comb begin
        divisor_ext = {1'b0, divisor_q};
        rem_sub     = rem_q - divisor_ext;
        q_bit       = (rem_q >= divisor_ext);
        rem_next    = q_bit ? {rem_sub[SW-1:0], 1'b0} : {rem_q[SW-1:0], 1'b0};
    end

    // Next-state logic, datapath register updates and registered output values
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        qsr_d     = qsr_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        ready_d   = 1'b0;
        quot_d    = quot_q;
        sticky_d  = sticky_q;
        dz_d      = dz_q;

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    divisor_d = Data_B_i;
                    rem_d     = {1'b0, Data_A_i};
                    qsr_d     = '0;
                    cnt_d     = '0;
                    if (Data_B_i == '0) begin
                        // Division by zero: saturate the quotient and finish immediately
                        state_d  = StDone;
                        ready_d  = 1'b1;
                        quot_d   = '1;
                        sticky_d = 1'b0;
                        dz_d     = 1'b1;
                    end else begin
                        state_d = StCalc;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StCalc: begin
                rem_d = rem_next;
                qsr_d = {qsr_q[SW-1:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SW)) begin
                    // Last of the SW+1 iterations: publish the result
                    state_d  = StDone;
                    ready_d  = 1'b1;
                    quot_d   = {qsr_q[SW-1:0], q_bit};
                    sticky_d = (rem_next != '0);
                    dz_d     = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            divisor_q <= '0;
            qsr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            quot_q    <= '0;
            sticky_q  <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            qsr_q     <= qsr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            quot_q    <= quot_d;
            sticky_q  <= sticky_d;
            dz_q      <= dz_d;
        end
    end

    assign busy_o     = busy_q;
    assign ready_o    = ready_q;
    assign sgf_quot_o = quot_q;
    assign sticky_o   = sticky_q;
    assign div_zero_o = dz_q;

endmodule

// File: tb/tb_sgf_divider_seq.sv
// Scoreboard bench for sgf_divider_seq: the driver pushes expected results
// with their expected ready cycle, and a monitor pops and checks on every ready_o.
module tb_sgf_divider_seq;

    localparam int unsigned SW = 24;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [SW-1:0] Data_A_i;
    logic [SW-1:0] Data_B_i;
    logic          busy_o;
    logic          ready_o;
    logic [SW:0]   sgf_quot_o;
    logic          sticky_o;
    logic          div_zero_o;

    typedef struct packed {
        logic [SW:0] quot;
        logic        sticky;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          tests;
    int          fails;

    sgf_divider_seq #(
        .SW(SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .Data_A_i  (Data_A_i),
        .Data_B_i  (Data_B_i),
        .busy_o    (busy_o),
        .ready_o   (ready_o),
        .sgf_quot_o(sgf_quot_o),
        .sticky_o  (sticky_o),
        .div_zero_o(div_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && ready_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quot", 64'(sgf_quot_o), 64'(e.quot));
                check("sticky", 64'(sticky_o), 64'(e.sticky));
                check("div_zero", 64'(div_zero_o), 64'(e.dz));
                check("ready_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_in_done", 64'(busy_o), 64'd0);
            end
        end
    end

    // Drive one request for a single edge; called just after a negedge.
    task automatic issue(input logic [SW-1:0] a, input logic [SW-1:0] b,
                         input logic [SW:0] eq, input logic es, input logic ed,
                         input int unsigned lat);
        exp_t e;
        start_i  = 1'b1;
        Data_A_i = a;
        Data_B_i = b;
        e.quot   = eq;
        e.sticky = es;
        e.dz     = ed;
        e.cyc    = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        start_i  = 1'b0;
        Data_A_i = $urandom();
        Data_B_i = $urandom();
    endtask

    // Wait (bounded) for all pending results, then check ready drops again.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
        check("ready_one_cycle", 64'(ready_o), 64'd0);
    endtask

    // Reference model for normalized operands
    task automatic ref_div(input logic [SW-1:0] a, input logic [SW-1:0] b,
                           output logic [SW:0] q, output logic s);
        logic [63:0] n;
        logic [63:0] qq;
        n  = 64'(a) << SW;
        qq = n / 64'(b);
        q  = qq[SW:0];
        s  = ((n % 64'(b)) != 64'd0);
    endtask

    initial begin
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        logic [SW:0]   eq;
        logic          es;
        int            n;

        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        start_i  = 1'b0;
        Data_A_i = '0;
        Data_B_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_quot", 64'(sgf_quot_o), 64'd0);
        check("rst_sticky", 64'(sticky_o), 64'd0);
        check("rst_dz", 64'(div_zero_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: 1.0 / 1.0
        issue(24'h800000, 24'h800000, 25'h1000000, 1'b0, 1'b0, SW + 1);
        check("busy_after_e0", 64'(busy_o), 64'd1);
        drain();

        // 2: 1.5 / 1.0 and 1.0 / 1.5
        issue(24'hC00000, 24'h800000, 25'h1800000, 1'b0, 1'b0, SW + 1);
        drain();
        issue(24'h800000, 24'hC00000, 25'h0AAAAAA, 1'b1, 1'b0, SW + 1);
        drain();

        // 3: divide by zero finishes right after the accepting edge
        issue(24'h9A0000, 24'h000000, 25'h1FFFFFF, 1'b0, 1'b1, 0);
        check("dz_busy", 64'(busy_o), 64'd0);
        drain();

        // 4: a second start during CALC is ignored
        issue(24'hC00000, 24'h800000, 25'h1800000, 1'b0, 1'b0, SW + 1);
        repeat (4) @(negedge clk);
        start_i  = 1'b1;
        Data_A_i = 24'h800000;
        Data_B_i = 24'hC00000;
        @(negedge clk);
        start_i  = 1'b0;
        drain();

        // 5: asynchronous reset mid-CALC aborts without a ready pulse
        start_i  = 1'b1;
        Data_A_i = 24'h800000;
        Data_B_i = 24'hC00000;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_quot", 64'(sgf_quot_o), 64'd0);
        check("abort_dz", 64'(div_zero_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        issue(24'h800000, 24'h800000, 25'h1000000, 1'b0, 1'b0, SW + 1);
        drain();

        // 6: start held in DONE chains a back-to-back operation
        issue(24'h800000, 24'hC00000, 25'h0AAAAAA, 1'b1, 1'b0, SW + 1);
        n = 0;
        while (ready_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready_seen", 64'(ready_o), 64'd1);
        issue(24'hC00000, 24'h800000, 25'h1800000, 1'b0, 1'b0, SW + 1);
        drain();

        // 6b: zero divisor repeated from DONE stays in DONE
        issue(24'hA00000, 24'h000000, 25'h1FFFFFF, 1'b0, 1'b1, 0);
        issue(24'hB00000, 24'h000000, 25'h1FFFFFF, 1'b0, 1'b1, 0);
        drain();

        // Random normalized pairs against the reference model
        for (int i = 0; i < 200; i++) begin
            a = SW'($urandom_range(32'hFFFFFF, 32'h800000));
            b = SW'($urandom_range(32'hFFFFFF, 32'h800000));
            ref_div(a, b, eq, es);
            issue(a, b, eq, es, 1'b0, SW + 1);
            drain();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
